// File: rtl/presort_chunk_unpacker.sv
// Splits presorted AXI words into per-chunk beats for the merge-tree leaves and
// monitors every emitted chunk for ascending key order.
module presort_chunk_unpacker #(
    parameter int AXI_DATA_WIDTH    = 512,
    parameter int DATA_WIDTH        = 32,
    parameter int KEY_WIDTH         = 32,
    parameter int INIT_SORTED_CHUNK = 8,
    localparam int LP_CHUNK_NUM     = AXI_DATA_WIDTH / DATA_WIDTH / INIT_SORTED_CHUNK,
    localparam int LP_CHUNK_BITS    = INIT_SORTED_CHUNK * DATA_WIDTH,
    localparam int LP_IDX_W         = (LP_CHUNK_NUM > 1) ? $clog2(LP_CHUNK_NUM) : 1
) (
    input  logic                      aclk,
    input  logic                      areset,
    input  logic                      s_axis_tvalid,
    output logic                      s_axis_tready,
    input  logic [AXI_DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                      s_axis_tlast,
    output logic                      m_axis_tvalid,
    input  logic                      m_axis_tready,
    output logic [LP_CHUNK_BITS-1:0]  m_axis_tdata,
    output logic                      m_axis_tlast,
    output logic [LP_IDX_W-1:0]       m_chunk_idx,
    input  logic                      i_err_clr,
    output logic                      o_order_err,
    output logic [15:0]               o_err_cnt
);

    localparam logic [LP_IDX_W-1:0] LP_LAST_IDX = LP_IDX_W'(LP_CHUNK_NUM - 1);

    // Any adjacent pair with key[j] > key[j+1] (unsigned) marks the chunk as unsorted.
    function automatic logic chunk_unsorted(input logic [LP_CHUNK_BITS-1:0] chunk);
        logic bad;
        bad = 1'b0;
        for (int j = 0; j < INIT_SORTED_CHUNK - 1; j++) begin
            if (chunk[j*DATA_WIDTH +: KEY_WIDTH] > chunk[(j+1)*DATA_WIDTH +: KEY_WIDTH]) begin
                bad = 1'b1;
            end else begin
                bad = bad;
            end
        end
        return bad;
    endfunction

    logic [AXI_DATA_WIDTH-1:0] buf_data_q, buf_data_d;
    logic                      buf_last_q, buf_last_d;
    logic                      buf_valid_q, buf_valid_d;
    logic [LP_IDX_W-1:0]       idx_q, idx_d;
    logic                      order_err_q, order_err_d;
    logic [15:0]               err_cnt_q, err_cnt_d;
    logic [LP_CHUNK_BITS-1:0]  chunk_s;
    logic                      last_chunk_s;
    logic                      out_hs_s;
    logic                      in_hs_s;

    assign last_chunk_s  = (idx_q == LP_LAST_IDX);
    assign out_hs_s      = buf_valid_q && m_axis_tready;
    assign s_axis_tready = !areset && (!buf_valid_q || (out_hs_s && last_chunk_s));
    assign in_hs_s       = s_axis_tvalid && s_axis_tready;

    assign m_axis_tvalid = buf_valid_q;
    assign m_axis_tdata  = chunk_s;
    assign m_axis_tlast  = buf_last_q && last_chunk_s;
    assign m_chunk_idx   = idx_q;
    assign o_order_err   = order_err_q;
    assign o_err_cnt     = err_cnt_q;

    // Select the chunk addressed by idx from the buffered word.
    always_comb begin
        chunk_s = buf_data_q[0 +: LP_CHUNK_BITS];
        for (int c = 0; c < LP_CHUNK_NUM; c++) begin
            if (idx_q == LP_IDX_W'(c)) begin
                chunk_s = buf_data_q[c*LP_CHUNK_BITS +: LP_CHUNK_BITS];
            end else begin
                chunk_s = chunk_s;
            end
        end
    end

    // Word buffer and chunk index: a new word may reload on the edge that drains the last chunk.
    always_comb begin
        buf_data_d  = buf_data_q;
        buf_last_d  = buf_last_q;
        buf_valid_d = buf_valid_q;
        idx_d       = idx_q;
        if (in_hs_s) begin
            buf_data_d  = s_axis_tdata;
            buf_last_d  = s_axis_tlast;
            buf_valid_d = 1'b1;
            idx_d       = {LP_IDX_W{1'b0}};
        end else if (out_hs_s) begin
            if (last_chunk_s) begin
                buf_valid_d = 1'b0;
                idx_d       = {LP_IDX_W{1'b0}};
            end else begin
                idx_d = idx_q + {{(LP_IDX_W-1){1'b0}}, 1'b1};
            end
        end else begin
            idx_d = idx_q;
        end
    end

    // Sticky order flag and saturating counter; a violation wins over a same-cycle clear.
    always_comb begin
        order_err_d = order_err_q;
        err_cnt_d   = err_cnt_q;
        if (out_hs_s && chunk_unsorted(chunk_s)) begin
            order_err_d = 1'b1;
            if (i_err_clr) begin
                err_cnt_d = 16'd1;
            end else if (err_cnt_q != 16'hFFFF) begin
                err_cnt_d = err_cnt_q + 16'd1;
            end else begin
                err_cnt_d = err_cnt_q;
            end
        end else if (i_err_clr) begin
            order_err_d = 1'b0;
            err_cnt_d   = 16'd0;
        end else begin
            order_err_d = order_err_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge aclk) begin
        if (areset) begin
            buf_data_q  <= {AXI_DATA_WIDTH{1'b0}};
            buf_last_q  <= 1'b0;
            buf_valid_q <= 1'b0;
            idx_q       <= {LP_IDX_W{1'b0}};
            order_err_q <= 1'b0;
            err_cnt_q   <= 16'd0;
        end else begin
            buf_data_q  <= buf_data_d;
            buf_last_q  <= buf_last_d;
            buf_valid_q <= buf_valid_d;
            idx_q       <= idx_d;
            order_err_q <= order_err_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

endmodule

// File: tb/tb_presort_chunk_unpacker.sv
// Directed bench for presort_chunk_unpacker at default parameters
// (two 8-element chunks of 32-bit elements per 512-bit word).
module tb_presort_chunk_unpacker;

    logic         clk = 1'b0;
    logic         areset;
    logic         s_valid, s_ready, s_last;
    logic [511:0] s_data;
    logic         m_valid, m_ready, m_last;
    logic [255:0] m_data;
    logic [0:0]   m_idx;
    logic         err_clr, order_err;
    logic [15:0]  err_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    presort_chunk_unpacker dut (
        .aclk          (clk),
        .areset        (areset),
        .s_axis_tvalid (s_valid),
        .s_axis_tready (s_ready),
        .s_axis_tdata  (s_data),
        .s_axis_tlast  (s_last),
        .m_axis_tvalid (m_valid),
        .m_axis_tready (m_ready),
        .m_axis_tdata  (m_data),
        .m_axis_tlast  (m_last),
        .m_chunk_idx   (m_idx),
        .i_err_clr     (err_clr),
        .o_order_err   (order_err),
        .o_err_cnt     (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Chunk of 8 elements base, base+1, ..., element 0 in the LSBs.
    function automatic logic [255:0] mk_chunk(input int base);
        logic [255:0] c;
        for (int i = 0; i < 8; i++) c[i*32 +: 32] = 32'(base + i);
        return c;
    endfunction

    function automatic logic [511:0] mk_word(input int base);
        return {mk_chunk(base + 8), mk_chunk(base)};
    endfunction

    logic [255:0] bad1, desc, flat;

    initial begin
        areset = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0;
        m_ready = 1'b0; err_clr = 1'b0;
        bad1 = mk_chunk(8);
        bad1[3*32 +: 32] = 32'd3;
        for (int i = 0; i < 8; i++) desc[i*32 +: 32] = 32'(7 - i);
        for (int i = 0; i < 8; i++) flat[i*32 +: 32] = 32'd5;

        // Reset state
        cyc(); cyc();
        chk("rst_s_ready", s_ready, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_idx", m_idx, 0);
        chk("rst_tlast", m_last, 0);
        chk("rst_err", order_err, 0);
        chk("rst_cnt", err_cnt, 0);

        // 1: single ascending word with tlast
        areset = 1'b0; s_valid = 1'b1; s_data = mk_word(0); s_last = 1'b1; m_ready = 1'b1;
        #1;
        chk("t1_s_ready_empty", s_ready, 1);
        cyc();
        s_valid = 1'b0;
        #1;
        chk("t1_c0_valid", m_valid, 1);
        chk("t1_c0_data", m_data, mk_chunk(0));
        chk("t1_c0_idx", m_idx, 0);
        chk("t1_c0_last", m_last, 0);
        chk("t1_c0_s_ready", s_ready, 0);
        cyc();
        chk("t1_c1_data", m_data, mk_chunk(8));
        chk("t1_c1_idx", m_idx, 1);
        chk("t1_c1_last", m_last, 1);
        chk("t1_c1_s_ready", s_ready, 1);
        cyc();
        chk("t1_drained", m_valid, 0);
        chk("t1_err", order_err, 0);

        // 2: three words back-to-back, one chunk per cycle
        s_valid = 1'b1; s_data = mk_word(16); s_last = 1'b0;
        cyc();
        for (int w = 0; w < 3; w++) begin
            s_valid = (w < 2);
            s_data  = mk_word(32 + 16 * w);
            s_last  = (w == 1);
            #1;
            chk("t2_c0_data", m_data, mk_chunk(16 + 16 * w));
            chk("t2_c0_s_ready", s_ready, 0);
            cyc();
            chk("t2_c1_data", m_data, mk_chunk(24 + 16 * w));
            chk("t2_c1_valid", m_valid, 1);
            chk("t2_c1_s_ready", s_ready, 1);
            chk("t2_c1_last", m_last, (w == 2));
            cyc();
        end
        chk("t2_drained", m_valid, 0);

        // 3: stalls hold data and index
        s_valid = 1'b1; s_data = mk_word(64); s_last = 1'b0; m_ready = 1'b0;
        cyc();
        s_valid = 1'b0;
        cyc(); cyc();
        chk("t3_hold0_data", m_data, mk_chunk(64));
        chk("t3_hold0_idx", m_idx, 0);
        chk("t3_hold0_s_ready", s_ready, 0);
        m_ready = 1'b1;
        cyc();
        m_ready = 1'b0;
        cyc(); cyc();
        chk("t3_hold1_data", m_data, mk_chunk(72));
        chk("t3_hold1_idx", m_idx, 1);
        chk("t3_hold1_s_ready", s_ready, 0);
        m_ready = 1'b1;
        #1;
        chk("t3_s_ready_release", s_ready, 1);
        cyc();
        chk("t3_drained", m_valid, 0);

        // 4: unsorted chunk 1, then clear coinciding with a second violation
        s_valid = 1'b1; s_data = {bad1, mk_chunk(0)};
        cyc();
        s_valid = 1'b0;
        cyc();
        chk("t4_pre_err", order_err, 0);
        chk("t4_bad_data", m_data, bad1);
        cyc();
        chk("t4_err", order_err, 1);
        chk("t4_cnt", err_cnt, 1);
        s_valid = 1'b1;
        cyc();
        s_valid = 1'b0;
        cyc();
        err_clr = 1'b1;
        cyc();
        err_clr = 1'b0;
        chk("t4_clr_viol_err", order_err, 1);
        chk("t4_clr_viol_cnt", err_cnt, 1);
        err_clr = 1'b1;
        cyc();
        err_clr = 1'b0;
        chk("t4_clr_err", order_err, 0);
        chk("t4_clr_cnt", err_cnt, 0);
        s_valid = 1'b1; s_data = {flat, mk_chunk(0)};
        cyc();
        s_valid = 1'b0;
        cyc(); cyc();
        chk("t4_equal_keys_ok", err_cnt, 0);

        // 5: reset mid-word discards the buffer
        s_valid = 1'b1; s_data = mk_word(100);
        cyc();
        s_valid = 1'b0;
        cyc();
        chk("t5_mid_idx", m_idx, 1);
        areset = 1'b1;
        #1;
        chk("t5_s_ready_rst", s_ready, 0);
        cyc();
        chk("t5_valid_rst", m_valid, 0);
        chk("t5_idx_rst", m_idx, 0);
        areset = 1'b0; s_valid = 1'b1; s_data = mk_word(200);
        cyc();
        s_valid = 1'b0;
        chk("t5_new_idx", m_idx, 0);
        chk("t5_new_data", m_data, mk_chunk(200));
        cyc(); cyc();
        chk("t5_drained", m_valid, 0);

        // 6: counter saturation with a continuous stream of unsorted chunks
        s_valid = 1'b1; s_data = {desc, desc};
        cyc();
        repeat (65534) cyc();
        chk("t6_cnt_fffe", err_cnt, 16'hFFFE);
        cyc();
        chk("t6_cnt_ffff", err_cnt, 16'hFFFF);
        cyc();
        chk("t6_cnt_sat", err_cnt, 16'hFFFF);
        chk("t6_err", order_err, 1);
        s_valid = 1'b0;
        cyc(); cyc();
        chk("t6_drained", m_valid, 0);
        err_clr = 1'b1;
        cyc();
        err_clr = 1'b0;
        chk("t6_clr_cnt", err_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
